// File: rtl/perf_sampler.sv
// Wishbone-mapped bus activity sampler: counts ack pulses on two monitored buses per
// programmable window and queues {A0,A1} samples in a small FIFO read back through DATA.
module perf_sampler #(
    parameter logic [31:0] BASE       = 32'h9900_0010,
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] PERIOD_RST = 32'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_wdat,
    output logic [31:0] wb_rdat,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty,
    input  logic        m0_ack,
    input  logic        m1_ack
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = 5;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    localparam logic [31:0] ADR_CTRL   = BASE;
    localparam logic [31:0] ADR_PERIOD = BASE + 32'h4;
    localparam logic [31:0] ADR_STATUS = BASE + 32'h8;
    localparam logic [31:0] ADR_DATA   = BASE + 32'hC;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             bus_ready_q;
    logic [31:0]      period_q;
    logic [31:0]      tmr_q;
    logic [15:0]      a0_q;
    logic [15:0]      a1_q;
    logic             ovf_q;
    logic [LVL_W-1:0] level_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [31:0]      mem [DEPTH];

    logic             acc;
    logic             wr_ctrl;
    logic             wr_period;
    logic             rd_data;
    logic             clr;
    logic             start_run;
    logic             tick;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic             ovf_set;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      reload;
    logic [15:0]      a0_inc;
    logic [15:0]      a1_inc;
    logic [31:0]      rd_val;

    assign wb_err = 1'b0;
    assign wb_rty = 1'b0;

    // A transaction only counts once the strobe has been seen low after reset,
    // so an access interrupted by reset is never acknowledged.
    assign acc       = wb_cyc & wb_stb & ~wb_ack & bus_ready_q;
    assign wr_ctrl   = acc & wb_we & (wb_adr == ADR_CTRL);
    assign wr_period = acc & wb_we & (wb_adr == ADR_PERIOD);
    assign rd_data   = acc & ~wb_we & (wb_adr == ADR_DATA);
    assign clr       = wr_ctrl & wb_wdat[1];

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign reload     = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
    assign a0_inc     = (a0_q == 16'hFFFF) ? a0_q : a0_q + 16'(m0_ack);
    assign a1_inc     = (a1_q == 16'hFFFF) ? a1_q : a1_q + 16'(m1_ack);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle sampling controls
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        tick      = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ctrl && wb_wdat[0]) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                tick = 1'b1;
                push = (tmr_q == 32'd0);
                if (wr_ctrl && !wb_wdat[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous push and pop always succeed, even when full
    assign pop     = rd_data & ~fifo_empty;
    assign push_ok = push & ~clr & (~fifo_full | pop);
    assign ovf_set = push & ~clr & fifo_full & ~pop;

    // Register read mux
    always_comb begin
        rd_val = 32'd0;
        if (wb_adr == ADR_CTRL) begin
            rd_val = {31'd0, state_q == RUN};
        end else if (wb_adr == ADR_PERIOD) begin
            rd_val = period_q;
        end else if (wb_adr == ADR_STATUS) begin
            rd_val = {24'd0, ovf_q, fifo_full, fifo_empty, level_q};
        end else if (wb_adr == ADR_DATA) begin
            rd_val = fifo_empty ? 32'd0 : mem[rptr_q];
        end
    end

    // Bus response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ready_q <= 1'b0;
            wb_ack      <= 1'b0;
            wb_rdat     <= 32'd0;
        end else begin
            if (!(wb_cyc && wb_stb)) begin
                bus_ready_q <= 1'b1;
            end
            wb_ack  <= acc;
            wb_rdat <= (acc && !wb_we) ? rd_val : 32'd0;
        end
    end

    // Window timer, accumulators, period register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= PERIOD_RST;
            tmr_q    <= 32'd0;
            a0_q     <= 16'd0;
            a1_q     <= 16'd0;
        end else begin
            if (wr_period) begin
                period_q <= wb_wdat;
            end
            if (start_run) begin
                tmr_q <= reload;
                a0_q  <= 16'd0;
                a1_q  <= 16'd0;
            end else if (tick) begin
                if (tmr_q == 32'd0) begin
                    tmr_q <= reload;
                    a0_q  <= 16'd0;
                    a1_q  <= 16'd0;
                end else begin
                    tmr_q <= tmr_q - 32'd1;
                    a0_q  <= a0_inc;
                    a1_q  <= a1_inc;
                end
            end
        end
    end

    // FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (push_ok && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push_ok) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Sample storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= {a0_inc, a1_inc};
        end
    end

endmodule

// File: tb/tb_perf_sampler.sv
// Directed bench for perf_sampler: a queue-based reference model checked every cycle,
// plus literal register readbacks for the characteristic scenarios.
module tb_perf_sampler;

    localparam logic [31:0] BASE       = 32'h9900_0010;
    localparam int unsigned DEPTH      = 8;
    localparam logic [31:0] PERIOD_RST = 32'd1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_adr = 32'd0;
    logic [31:0] wb_wdat = 32'd0;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;
    logic        m0_ack = 1'b0;
    logic        m1_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    perf_sampler #(.BASE(BASE), .DEPTH(DEPTH), .PERIOD_RST(PERIOD_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_wdat(wb_wdat), .wb_rdat(wb_rdat),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .m0_ack(m0_ack), .m1_ack(m1_ack)
    );

    always #5 clk = ~clk;

    // Reference model: window counted upward, samples kept in a queue
    logic [31:0] m_fifo[$];
    logic [31:0] m_period = PERIOD_RST;
    bit          m_run = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_a0 = 0, m_a1 = 0, m_cnt = 0, m_win = 1;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdat = 32'd0;

    function automatic int unsigned eff(input logic [31:0] p);
        return (p == 32'd0) ? 1 : int'(p);
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_period = PERIOD_RST;
        m_run = 1'b0; m_ovf = 1'b0;
        m_a0 = 0; m_a1 = 0; m_cnt = 0; m_win = 1;
        m_ack = 1'b0; m_rdat = 32'd0;
    endtask

    task automatic model_step();
        bit push = 1'b0, pop = 1'b0, clr = 1'b0, acc;
        logic [31:0] smp = 32'd0, rd = 32'd0;
        int unsigned s0, s1;
        acc = wb_cyc && wb_stb && !m_ack;
        if (m_run) begin
            s0 = sat(m_a0 + int'(m0_ack));
            s1 = sat(m_a1 + int'(m1_ack));
            m_cnt++;
            if (m_cnt >= m_win) begin
                push = 1'b1;
                smp = {16'(s0), 16'(s1)};
                m_cnt = 0; m_a0 = 0; m_a1 = 0;
                m_win = eff(m_period);
            end else begin
                m_a0 = s0; m_a1 = s1;
            end
        end
        if (acc && !wb_we) begin
            case (wb_adr)
                BASE:          rd = {31'd0, m_run};
                BASE + 32'h4:  rd = m_period;
                BASE + 32'h8:  rd = {24'd0, m_ovf, m_fifo.size() == DEPTH, m_fifo.size() == 0, 5'(m_fifo.size())};
                BASE + 32'hC:  if (m_fifo.size() > 0) begin rd = m_fifo[0]; pop = 1'b1; end
                default:       rd = 32'd0;
            endcase
        end else if (acc) begin
            case (wb_adr)
                BASE: begin
                    clr = wb_wdat[1];
                    if (wb_wdat[0] && !m_run) begin
                        m_run = 1'b1; m_cnt = 0; m_a0 = 0; m_a1 = 0;
                        m_win = eff(m_period);
                    end else if (!wb_wdat[0]) begin
                        m_run = 1'b0;
                    end
                end
                BASE + 32'h4: m_period = wb_wdat;
                default: ;
            endcase
        end
        if (clr) begin
            m_fifo.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(smp);
                else m_ovf = 1'b1;
            end
        end
        m_ack = acc;
        m_rdat = rd;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            chk("ack", {31'd0, wb_ack}, {31'd0, m_ack});
            chk("rdat", wb_rdat, m_rdat);
            chk("err_rty", {30'd0, wb_err, wb_rty}, 32'd0);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 4);
        chk("ack_latency", 32'(n), 32'd1);
        rd = wb_rdat;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus(1'b1, adr, d, unused_rd);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, adr, 32'd0, v);
        chk(name, v, exp);
    endtask

    task automatic stimulus();
        localparam logic [31:0] CTRL = BASE, PER = BASE + 32'h4, STAT = BASE + 32'h8, DATA = BASE + 32'hC;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        rd_chk("rst_ctrl", CTRL, 32'd0);
        rd_chk("rst_period", PER, 32'd1000);
        rd_chk("rst_status", STAT, 32'h20);

        // One 4-cycle window: 3 m0 acks, 1 m1 ack
        wr(PER, 32'd4);
        wr(CTRL, 32'd1);
        m0_ack = 1'b1; m1_ack = 1'b1;
        @(negedge clk); m1_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); m0_ack = 1'b0;
        wr(CTRL, 32'd0);
        rd_chk("win_status", STAT, 32'h01);
        rd_chk("win_data", DATA, 32'h0003_0001);
        rd_chk("win_empty", STAT, 32'h20);

        // PERIOD=1 overflows, pop while full, then CLR
        wr(PER, 32'd1);
        m1_ack = 1'b1;
        wr(CTRL, 32'd1);
        repeat (10) @(negedge clk);
        rd_chk("full_pop", DATA, 32'h0000_0001);
        wr(CTRL, 32'd0);
        m1_ack = 1'b0;
        rd_chk("ovf_status", STAT, 32'hC8);
        wr(CTRL, 32'd2);
        rd_chk("clr_status", STAT, 32'h20);

        // Pop coincides with push into a full FIFO: no overflow
        wr(PER, 32'd3);
        m1_ack = 1'b1;
        wr(CTRL, 32'd1);
        repeat (25) @(negedge clk);
        rd_chk("coinc_data", DATA, 32'h0000_0003);
        wr(CTRL, 32'd0);
        m1_ack = 1'b0;
        rd_chk("coinc_status", STAT, 32'h48);
        wr(CTRL, 32'd2);

        // PERIOD=0 pushes every cycle
        wr(PER, 32'd0);
        wr(CTRL, 32'd1);
        repeat (2) @(negedge clk);
        wr(CTRL, 32'd0);
        rd_chk("p0_status", STAT, 32'h04);
        wr(CTRL, 32'd2);

        // Empty pop and unmapped space
        rd_chk("empty_data", DATA, 32'd0);
        rd_chk("empty_status", STAT, 32'h20);
        rd_chk("unmapped_rd", BASE + 32'h20, 32'd0);
        wr(BASE + 32'h20, 32'hFFFF_FFFF);
        rd_chk("unmapped_wr", PER, 32'd0);

        // Accumulator saturation over a long window
        wr(PER, 32'd70000);
        m0_ack = 1'b1;
        wr(CTRL, 32'd1);
        repeat (70002) @(negedge clk);
        wr(CTRL, 32'd0);
        m0_ack = 1'b0;
        rd_chk("sat_data", DATA, 32'hFFFF_0000);

        // Reset during RUN with 3 samples queued, mid-transaction
        wr(PER, 32'd2);
        wr(CTRL, 32'd1);
        repeat (5) @(negedge clk);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = STAT;
        @(posedge clk); #2;
        chk("pre_rst_ack", {31'd0, wb_ack}, 32'd1);
        chk("pre_rst_status", wb_rdat, 32'h03);
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        chk("rst_ack_now", {31'd0, wb_ack}, 32'd0);
        chk("rst_rdat_now", wb_rdat, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_status", STAT, 32'h20);
        rd_chk("post_rst_ctrl", CTRL, 32'd0);
        rd_chk("post_rst_period", PER, 32'd1000);
        rd_chk("post_rst_data", DATA, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
